// File: rtl/bram_pkg.sv
// Shared constants and types for the dual-port byte-enable block RAM.
package bram_pkg;

  localparam int RDW_WRITE_FIRST = 0;
  localparam int RDW_READ_FIRST  = 1;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_e;

  function automatic int nb(input int data_w, input int lane_w);
    return data_w / lane_w;
  endfunction

endpackage

// File: rtl/bram_clear_seq.sv
// Post-reset clear sequencer: walks every address once, emitting a zero-write
// request per cycle, and reports busy until the last word is written.
module bram_clear_seq
  import bram_pkg::*;
#(
  parameter int ADDR           = 12,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  output logic            busy,
  output logic            clr_we,
  output logic [ADDR-1:0] clr_addr
);

  clr_state_e      state, state_nx;
  logic [ADDR-1:0] ptr, ptr_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR_ON_RESET ? CLR_RUN : CLR_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    clr_we   = 1'b0;
    if (state == CLR_RUN) begin
      clr_we = 1'b1;
      ptr_nx = ptr + 1'b1;
      if (ptr == '1) state_nx = CLR_IDLE;
    end
  end

  // busy is the registered state, so it falls on the edge that writes the last word
  assign busy     = (state == CLR_RUN);
  assign clr_addr = ptr;

endmodule

// File: rtl/bram_dp_be.sv
// True dual-port block RAM with per-byte write enables, selectable same-port
// read-during-write behaviour, optional output register and post-reset clear.
module bram_dp_be
  import bram_pkg::*;
#(
  parameter int DATA           = 16,
  parameter int ADDR           = 12,
  parameter int BYTE           = 8,
  parameter int RDW_MODE       = RDW_WRITE_FIRST,
  parameter bit OUT_REG        = 1'b0,
  parameter bit CLEAR_ON_RESET = 1'b1,
  localparam int NB            = nb(DATA, BYTE)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            busy,
  input  logic            a_en,
  input  logic [NB-1:0]   a_we,
  input  logic [ADDR-1:0] a_addr,
  input  logic [DATA-1:0] a_din,
  output logic [DATA-1:0] a_dout,
  output logic            a_valid,
  input  logic            b_en,
  input  logic [NB-1:0]   b_we,
  input  logic [ADDR-1:0] b_addr,
  input  logic [DATA-1:0] b_din,
  output logic [DATA-1:0] b_dout,
  output logic            b_valid
);

  if (DATA % BYTE != 0) begin : g_bad_cfg
    $error("bram_dp_be: DATA must be a multiple of BYTE");
  end

  logic [DATA-1:0] mem [2**ADDR];

  logic            clr_we;
  logic [ADDR-1:0] clr_addr;

  bram_clear_seq #(
    .ADDR          (ADDR),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_clr (
    .clk     (clk),
    .rst     (rst),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_addr(clr_addr)
  );

  function automatic logic [DATA-1:0] merge(input logic [DATA-1:0] old_w,
                                            input logic [DATA-1:0] new_w,
                                            input logic [NB-1:0]   we);
    logic [DATA-1:0] r;
    r = old_w;
    for (int i = 0; i < NB; i++)
      if (we[i]) r[i*BYTE +: BYTE] = new_w[i*BYTE +: BYTE];
    return r;
  endfunction

  logic            a_acc, b_acc;
  logic [NB-1:0]   wa_we, wb_we;
  logic [ADDR-1:0] wa_addr;
  logic [DATA-1:0] wa_din;

  assign a_acc = a_en & ~busy;
  assign b_acc = b_en & ~busy;

  // The clear sequencer borrows port A's write path while busy
  assign wa_we   = busy ? {NB{clr_we}} : (a_acc ? a_we : '0);
  assign wa_addr = busy ? clr_addr : a_addr;
  assign wa_din  = busy ? '0 : a_din;
  assign wb_we   = b_acc ? b_we : '0;

  // Port A lanes are written after port B so A wins lanes both ports enable
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++)
      if (wb_we[i]) mem[b_addr][i*BYTE +: BYTE] <= b_din[i*BYTE +: BYTE];
    for (int i = 0; i < NB; i++)
      if (wa_we[i]) mem[wa_addr][i*BYTE +: BYTE] <= wa_din[i*BYTE +: BYTE];
  end

  logic [DATA-1:0] a_old, b_old, a_rd, b_rd;

  // Reads see pre-write contents, so cross-port collisions return the old word
  assign a_old = mem[a_addr];
  assign b_old = mem[b_addr];
  assign a_rd  = (RDW_MODE == RDW_READ_FIRST) ? a_old : merge(a_old, a_din, a_we);
  assign b_rd  = (RDW_MODE == RDW_READ_FIRST) ? b_old : merge(b_old, b_din, b_we);

  logic [DATA-1:0] a_q, b_q;
  logic            a_vq, b_vq;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      a_vq <= 1'b0;
      b_vq <= 1'b0;
    end else begin
      a_vq <= a_acc;
      b_vq <= b_acc;
      if (a_acc) a_q <= a_rd;
      if (b_acc) b_q <= b_rd;
    end
  end

  if (OUT_REG) begin : g_oreg
    always_ff @(posedge clk) begin
      if (rst) begin
        a_dout  <= '0;
        b_dout  <= '0;
        a_valid <= 1'b0;
        b_valid <= 1'b0;
      end else begin
        a_valid <= a_vq;
        b_valid <= b_vq;
        if (a_vq) a_dout <= a_q;
        if (b_vq) b_dout <= b_q;
      end
    end
  end else begin : g_noreg
    assign a_dout  = a_q;
    assign b_dout  = b_q;
    assign a_valid = a_vq;
    assign b_valid = b_vq;
  end

endmodule

// File: tb/tb_bram_dp_be.sv
// Bench for bram_dp_be: three configurations share one stimulus stream and are
// checked against a reference memory through per-port expectation queues.
module tb_bram_dp_be;

  localparam int AW = 4;
  localparam int DEPTH = 2**AW;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          a_en, b_en;
  logic [1:0]    a_we, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [15:0]   a_din, b_din;

  logic        busy [3];
  logic        a_valid [3];
  logic        b_valid [3];
  logic [15:0] a_dout [3];
  logic [15:0] b_dout [3];

  // u0: write-first, latency 1; u1: read-first, latency 1; u2: write-first, latency 2
  bram_dp_be #(.DATA(16), .ADDR(AW), .BYTE(8), .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)) u0 (
    .clk(clk), .rst(rst), .busy(busy[0]),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout[0]), .a_valid(a_valid[0]),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout[0]), .b_valid(b_valid[0]));
  bram_dp_be #(.DATA(16), .ADDR(AW), .BYTE(8), .RDW_MODE(1), .OUT_REG(0), .CLEAR_ON_RESET(1)) u1 (
    .clk(clk), .rst(rst), .busy(busy[1]),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout[1]), .a_valid(a_valid[1]),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout[1]), .b_valid(b_valid[1]));
  bram_dp_be #(.DATA(16), .ADDR(AW), .BYTE(8), .RDW_MODE(0), .OUT_REG(1), .CLEAR_ON_RESET(1)) u2 (
    .clk(clk), .rst(rst), .busy(busy[2]),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout[2]), .a_valid(a_valid[2]),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout[2]), .b_valid(b_valid[2]));

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [15:0] mm [DEPTH];
  exp_t        q [6][$];   // index = instance*2 + port (0 = A, 1 = B)

  function automatic logic [15:0] lane_merge(input logic [15:0] old_w, input logic [15:0] new_w,
                                             input logic [1:0] we);
    return {we[1] ? new_w[15:8] : old_w[15:8], we[0] ? new_w[7:0] : old_w[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic check_port(input int k, input logic v, input logic [15:0] d);
    logic ev;
    exp_t e;
    ev = (q[k].size() != 0) && (q[k][0].cyc == cyc);
    tests++;
    assert (v === ev) else begin
      fails++;
      $error("FAIL valid[%0d] cyc=%0d observed=%b expected=%b", k, cyc, v, ev);
    end
    if (ev) begin
      e = q[k].pop_front();
      tests++;
      assert (d === e.data) else begin
        fails++;
        $error("FAIL dout[%0d] cyc=%0d observed=%h expected=%h", k, cyc, d, e.data);
      end
    end
    while (q[k].size() != 0 && q[k][0].cyc < cyc) void'(q[k].pop_front());
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_port(2*i,   a_valid[i], a_dout[i]);
      check_port(2*i+1, b_valid[i], b_dout[i]);
    end
  endtask

  task automatic push_port(input int port, input logic [15:0] old_w, input logic [15:0] din,
                           input logic [1:0] we);
    logic [15:0] wf;
    wf = lane_merge(old_w, din, we);
    q[port].push_back('{wf, cyc + 1});
    q[2 + port].push_back('{old_w, cyc + 1});
    q[4 + port].push_back('{wf, cyc + 2});
  endtask

  // One cycle of stimulus; blocked marks accesses the DUT must ignore (busy)
  task automatic drive(input logic ae, input logic [1:0] awe, input logic [AW-1:0] aad,
                       input logic [15:0] ad, input logic be, input logic [1:0] bwe,
                       input logic [AW-1:0] bad, input logic [15:0] bd, input bit blocked);
    a_en = ae; a_we = awe; a_addr = aad; a_din = ad;
    b_en = be; b_we = bwe; b_addr = bad; b_din = bd;
    if (!blocked) begin
      if (ae) push_port(0, mm[aad], ad, awe);
      if (be) push_port(1, mm[bad], bd, bwe);
      if (be) mm[bad] = lane_merge(mm[bad], bd, bwe);
      if (ae) mm[aad] = lane_merge(mm[aad], ad, awe);
    end
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'b00, '0, 16'h0, 1'b0, 2'b00, '0, 16'h0, 1'b0);
  endtask

  // Counts busy cycles from the current negedge; optionally tries a write while busy
  task automatic busy_count(output int n, input bit poke);
    n = 0;
    while (busy[0] === 1'b1 && n < 40) begin
      n++;
      if (poke && n == 14)
        drive(1'b1, 2'b11, 4'd0, 16'hFFFF, 1'b1, 2'b11, 4'd1, 16'hFFFF, 1'b1);
      else
        idle(1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    a_en = 0; a_we = 0; a_addr = 0; a_din = 0;
    b_en = 0; b_we = 0; b_addr = 0; b_din = 0;
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      u0.mem[i] = 16'hFFFF;
      u1.mem[i] = 16'hFFFF;
      u2.mem[i] = 16'hFFFF;
      mm[i] = 16'h0000;
    end
    idle(2);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_busy%0d", k), {15'b0, busy[k]}, 16'h0001);
      chk($sformatf("rst_a_dout%0d", k), a_dout[k], 16'h0000);
      chk($sformatf("rst_b_dout%0d", k), b_dout[k], 16'h0000);
    end

    // full clear after reset
    rst = 1'b0;
    busy_count(n, 1'b0);
    chk("busy_len", 16'(n), 16'd16);
    for (int i = 0; i < DEPTH; i++)
      drive(1'b1, 2'b00, AW'(i), 16'h0, 1'b1, 2'b00, AW'(DEPTH - 1 - i), 16'h0, 1'b0);
    idle(2);

    // reset asserted mid-clear restarts the sequence
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(7);
    chk("mid_busy", {15'b0, busy[0]}, 16'h0001);
    rst = 1'b1;
    idle(1);
    chk("rerst_busy", {15'b0, busy[0]}, 16'h0001);
    rst = 1'b0;
    busy_count(n, 1'b1);
    chk("busy_len_restart", 16'(n), 16'd16);
    chk("busy_after1", {15'b0, busy[1]}, 16'h0000);
    chk("busy_after2", {15'b0, busy[2]}, 16'h0000);
    drive(1'b1, 2'b00, 4'd0, 16'h0, 1'b1, 2'b00, 4'd1, 16'h0, 1'b0);
    idle(3);

    // byte-lane write
    drive(1'b1, 2'b11, 4'd3, 16'h1234, 1'b0, 2'b00, 4'd0, 16'h0, 1'b0);
    drive(1'b1, 2'b10, 4'd3, 16'hAB00, 1'b0, 2'b00, 4'd0, 16'h0, 1'b0);
    drive(1'b1, 2'b00, 4'd3, 16'h0000, 1'b0, 2'b00, 4'd0, 16'h0, 1'b0);
    idle(3);
    for (int k = 0; k < 3; k++) chk($sformatf("byte_hold%0d", k), a_dout[k], 16'hAB34);

    // same-port read-during-write and cross-port read of the same address
    drive(1'b1, 2'b11, 4'd5, 16'h1111, 1'b0, 2'b00, 4'd0, 16'h0, 1'b0);
    drive(1'b1, 2'b11, 4'd5, 16'h2222, 1'b1, 2'b00, 4'd5, 16'h0, 1'b0);
    idle(3);
    chk("rdw_wf_a", a_dout[0], 16'h2222);
    chk("rdw_rf_a", a_dout[1], 16'h1111);
    chk("rdw_wf_reg_a", a_dout[2], 16'h2222);
    for (int k = 0; k < 3; k++) chk($sformatf("rdw_cross_b%0d", k), b_dout[k], 16'h1111);

    // both ports write one address: A owns lane 0, B alone owns lane 1
    drive(1'b1, 2'b01, 4'd9, 16'hAAAA, 1'b1, 2'b11, 4'd9, 16'hBBBB, 1'b0);
    drive(1'b1, 2'b00, 4'd9, 16'h0000, 1'b1, 2'b00, 4'd9, 16'h0000, 1'b0);
    idle(3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("coll_a%0d", k), a_dout[k], 16'hBBAA);
      chk($sformatf("coll_b%0d", k), b_dout[k], 16'hBBAA);
    end

    // back-to-back reads through the pipeline
    for (int i = 0; i < 3; i++)
      drive(1'b1, 2'b11, AW'(i), 16'h0010 + 16'(i), 1'b0, 2'b00, 4'd0, 16'h0, 1'b0);
    for (int i = 0; i < 3; i++)
      drive(1'b1, 2'b00, AW'(i), 16'h0, 1'b0, 2'b00, 4'd0, 16'h0, 1'b0);
    idle(3);
    chk("pipe_last", a_dout[2], 16'h0012);

    // mixed random traffic on both ports
    for (int i = 0; i < 60; i++)
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), AW'($urandom_range(0, DEPTH - 1)),
            16'($urandom), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            AW'($urandom_range(0, DEPTH - 1)), 16'($urandom), 1'b0);
    idle(4);

    n = 0;
    for (int k = 0; k < 6; k++) n += q[k].size();
    chk("queues_drained", 16'(n), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
